// File: rtl/gc_output_scheduler.sv
// Output scheduler for GarbledCircuit results.
// Classifies each dual-word result as label/key/table/mask, computes its flat
// storage address, buffers it in a 2-write/1-read FIFO and drains one word per
// cycle over a first-word-fall-through valid/ready port. The upstream has no
// backpressure, so events that do not fit are dropped whole and counted.
module gc_output_scheduler #(
  parameter int S     = 16,
  parameter int K     = 128,
  parameter int DEPTH = 8,
  parameter int AW    = 2*S+1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [2:0]    tag_t1,
  input  logic [S-1:0]  cid,
  input  logic [S-1:0]  index0_t1,
  input  logic [S-1:0]  index1_t1,
  input  logic [K-1:0]  data0_t1,
  input  logic [K-1:0]  data1_t1,
  input  logic [S-1:0]  cfg_input_size,
  input  logic [S-1:0]  cfg_and_count,
  input  logic [S-1:0]  cfg_cc,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [1:0]    out_type,
  output logic [AW-1:0] out_addr,
  output logic [K-1:0]  out_data,
  output logic          overflow,
  output logic [15:0]   drop_count,
  output logic          done
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  // Full-width address arithmetic; results are truncated to AW afterwards.
  localparam int FW = 2*S + 2;

  typedef enum logic [1:0] {
    T_LABEL = 2'd0,
    T_KEY   = 2'd1,
    T_TABLE = 2'd2,
    T_MASK  = 2'd3
  } wtype_t;

  function automatic logic [15:0] sat_add16(input logic [15:0] a, input logic [1:0] b);
    logic [16:0] s;
    s = {1'b0, a} + 17'(b);
    return s[16] ? 16'hFFFF : s[15:0];
  endfunction

  // FIFO storage (data path, not reset) and control state
  logic [1:0]    r_type_mem [DEPTH];
  logic [AW-1:0] r_addr_mem [DEPTH];
  logic [K-1:0]  r_data_mem [DEPTH];
  logic [PW-1:0] r_wr_ptr;
  logic [PW-1:0] r_rd_ptr;
  logic [CW-1:0] r_count;
  logic          r_overflow;
  logic [15:0]   r_drop_count;
  logic          r_finished;
  logic          r_done;

  logic          w_active;
  logic [1:0]    w_nwords;
  wtype_t        w_type;
  logic [AW-1:0] w_addr_a;
  logic [AW-1:0] w_addr_b;
  logic [K-1:0]  w_data_a;
  logic [K-1:0]  w_data_b;
  logic [FW-1:0] w_lbl0;
  logic [FW-1:0] w_lbl1;
  logic [FW-1:0] w_tbl0;
  logic [FW-1:0] w_tbl1;
  logic [CW-1:0] w_free;
  logic          w_fits;
  logic          w_accept;
  logic          w_drop;
  logic          w_pop;
  logic [PW-1:0] w_wr_ptr1;

  assign w_active  = !r_finished && (cid != cfg_cc);
  assign w_lbl0    = FW'(cid) * FW'(cfg_input_size) + FW'(index0_t1);
  assign w_lbl1    = FW'(cid) * FW'(cfg_input_size) + FW'(index1_t1);
  assign w_tbl0    = ((FW'(cid) * FW'(cfg_and_count)) << 1) + FW'(index0_t1);
  assign w_tbl1    = ((FW'(cid) * FW'(cfg_and_count)) << 1) + FW'(index1_t1);
  assign w_free    = CW'(DEPTH) - r_count;
  // Space is judged on the start-of-cycle count; a same-cycle pop is not credited.
  assign w_fits    = CW'(w_nwords) <= w_free;
  assign w_accept  = (w_nwords != 2'd0) && w_fits;
  assign w_drop    = (w_nwords != 2'd0) && !w_fits;
  assign w_pop     = (r_count != '0) && out_ready;
  assign w_wr_ptr1 = r_wr_ptr + PW'(1);

  // Decode the event into up to two ordered words (slot a drains first)
  always_comb begin
    w_nwords = 2'd0;
    w_type   = T_LABEL;
    w_addr_a = '0;
    w_addr_b = '0;
    w_data_a = '0;
    w_data_b = '0;
    if (w_active) begin
      if (tag_t1[2]) begin
        w_type = T_LABEL;
        case (tag_t1[1:0])
          2'b01: begin
            w_nwords = 2'd1;
            w_addr_a = w_lbl0[AW-1:0];
            w_data_a = data0_t1;
          end
          2'b10: begin
            w_nwords = 2'd1;
            w_addr_a = w_lbl1[AW-1:0];
            w_data_a = data1_t1;
          end
          2'b11: begin
            w_nwords = 2'd2;
            w_addr_a = w_lbl0[AW-1:0];
            w_addr_b = w_lbl1[AW-1:0];
            w_data_a = data0_t1;
            w_data_b = data1_t1;
          end
          default: w_nwords = 2'd0;
        endcase
      end else begin
        case (tag_t1[1:0])
          2'b01: begin
            w_type   = T_KEY;
            w_nwords = 2'd2;
            w_addr_a = AW'(0);
            w_addr_b = AW'(1);
            w_data_a = data0_t1;
            w_data_b = data1_t1;
          end
          2'b10: begin
            w_type   = T_TABLE;
            w_nwords = 2'd2;
            w_addr_a = w_tbl0[AW-1:0];
            w_addr_b = w_tbl1[AW-1:0];
            w_data_a = data0_t1;
            w_data_b = data1_t1;
          end
          2'b11: begin
            w_type   = T_MASK;
            w_nwords = 2'd1;
            w_addr_a = AW'(cid);
            w_data_a = data0_t1;
          end
          default: w_nwords = 2'd0;
        endcase
      end
    end
  end

  // Write accepted words into the FIFO storage
  always_ff @(posedge clk) begin
    if (w_accept) begin
      r_type_mem[r_wr_ptr] <= w_type;
      r_addr_mem[r_wr_ptr] <= w_addr_a;
      r_data_mem[r_wr_ptr] <= w_data_a;
      if (w_nwords == 2'd2) begin
        r_type_mem[w_wr_ptr1] <= w_type;
        r_addr_mem[w_wr_ptr1] <= w_addr_b;
        r_data_mem[w_wr_ptr1] <= w_data_b;
      end
    end
  end

  // Pointers, occupancy, drop accounting and completion tracking
  always_ff @(posedge clk) begin
    if (rst) begin
      r_wr_ptr     <= '0;
      r_rd_ptr     <= '0;
      r_count      <= '0;
      r_overflow   <= 1'b0;
      r_drop_count <= 16'd0;
      r_finished   <= 1'b0;
      r_done       <= 1'b0;
    end else begin
      if (w_accept)
        r_wr_ptr <= r_wr_ptr + PW'(w_nwords);
      if (w_pop)
        r_rd_ptr <= r_rd_ptr + PW'(1);
      r_count <= r_count + (w_accept ? CW'(w_nwords) : CW'(0)) - CW'(w_pop);
      if (w_drop) begin
        r_overflow   <= 1'b1;
        r_drop_count <= sat_add16(r_drop_count, w_nwords);
      end
      if (!r_finished && (cid == cfg_cc))
        r_finished <= 1'b1;
      if (r_finished && (r_count == '0))
        r_done <= 1'b1;
    end
  end

  assign out_valid  = (r_count != '0);
  assign out_type   = out_valid ? r_type_mem[r_rd_ptr] : 2'd0;
  assign out_addr   = out_valid ? r_addr_mem[r_rd_ptr] : '0;
  assign out_data   = out_valid ? r_data_mem[r_rd_ptr] : '0;
  assign overflow   = r_overflow;
  assign drop_count = r_drop_count;
  assign done       = r_done;

endmodule

// File: tb/tb_gc_output_scheduler.sv
// Self-checking bench for gc_output_scheduler: table-driven events feeding a
// scoreboard queue that a negedge monitor compares against popped words, plus
// directed sequences for latency, overflow, completion and reset.
module tb_gc_output_scheduler;

  localparam int S     = 16;
  localparam int K     = 128;
  localparam int DEPTH = 8;
  localparam int AW    = 2*S+1;

  logic          clk = 1'b0;
  logic          rst;
  logic [2:0]    tag_t1;
  logic [S-1:0]  cid;
  logic [S-1:0]  index0_t1;
  logic [S-1:0]  index1_t1;
  logic [K-1:0]  data0_t1;
  logic [K-1:0]  data1_t1;
  logic [S-1:0]  cfg_input_size;
  logic [S-1:0]  cfg_and_count;
  logic [S-1:0]  cfg_cc;
  logic          out_valid;
  logic          out_ready;
  logic [1:0]    out_type;
  logic [AW-1:0] out_addr;
  logic [K-1:0]  out_data;
  logic          overflow;
  logic [15:0]   drop_count;
  logic          done;

  gc_output_scheduler #(.S(S), .K(K), .DEPTH(DEPTH), .AW(AW)) dut (
    .clk(clk), .rst(rst), .tag_t1(tag_t1), .cid(cid),
    .index0_t1(index0_t1), .index1_t1(index1_t1),
    .data0_t1(data0_t1), .data1_t1(data1_t1),
    .cfg_input_size(cfg_input_size), .cfg_and_count(cfg_and_count), .cfg_cc(cfg_cc),
    .out_valid(out_valid), .out_ready(out_ready), .out_type(out_type),
    .out_addr(out_addr), .out_data(out_data), .overflow(overflow),
    .drop_count(drop_count), .done(done)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [1:0]    t;
    logic [AW-1:0] a;
    logic [K-1:0]  d;
  } exp_t;

  typedef struct {
    logic [2:0]   tag;
    logic [S-1:0] c;
    logic [S-1:0] i0;
    logic [S-1:0] i1;
    logic [K-1:0] d0;
    logic [K-1:0] d1;
    int           n;
    exp_t         e0;
    exp_t         e1;
  } vec_t;

  exp_t exp_q[$];
  vec_t vecs[9];
  int   total = 0;
  int   bad   = 0;

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s actual=%0h required=%0h", nm, act, req);
    end
  endtask

  function automatic exp_t mke(input logic [1:0] t, input logic [AW-1:0] a, input logic [K-1:0] d);
    exp_t e;
    e.t = t; e.a = a; e.d = d;
    return e;
  endfunction

  function automatic vec_t mkv(input logic [2:0] tag, input logic [S-1:0] c,
                               input logic [S-1:0] i0, input logic [S-1:0] i1,
                               input logic [K-1:0] d0, input logic [K-1:0] d1,
                               input int n, input exp_t e0, input exp_t e1);
    vec_t v;
    v.tag = tag; v.c = c; v.i0 = i0; v.i1 = i1; v.d0 = d0; v.d1 = d1;
    v.n = n; v.e0 = e0; v.e1 = e1;
    return v;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_evt(input logic [2:0] t, input logic [S-1:0] c,
                         input logic [S-1:0] i0, input logic [S-1:0] i1,
                         input logic [K-1:0] d0, input logic [K-1:0] d1);
    tag_t1 = t; cid = c; index0_t1 = i0; index1_t1 = i1;
    data0_t1 = d0; data1_t1 = d1;
  endtask

  // Scoreboard monitor: every word that pops must match the queue head.
  always @(negedge clk) begin
    if (!rst && out_valid === 1'b1 && out_ready === 1'b1) begin
      if (exp_q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL unexpected_word actual addr=%0h data=%0h required=none", out_addr, out_data);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        chk("mon_type", 128'(out_type), 128'(e.t));
        chk("mon_addr", 128'(out_addr), 128'(e.a));
        chk("mon_data", out_data, e.d);
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    exp_t z;
    z = mke(2'd0, '0, '0);
    vecs[0] = mkv(3'b001, 16'd0, 16'd0, 16'd0, 128'hA, 128'hB, 2,
                  mke(2'd1, 33'd0, 128'hA), mke(2'd1, 33'd1, 128'hB));
    vecs[1] = mkv(3'b111, 16'd2, 16'd1, 16'd3, 128'h11, 128'h22, 2,
                  mke(2'd0, 33'd9, 128'h11), mke(2'd0, 33'd11, 128'h22));
    vecs[2] = mkv(3'b101, 16'd2, 16'd1, 16'd3, 128'h33, 128'h44, 1,
                  mke(2'd0, 33'd9, 128'h33), z);
    vecs[3] = mkv(3'b110, 16'd3, 16'd0, 16'd2, 128'h55, 128'h66, 1,
                  mke(2'd0, 33'd14, 128'h66), z);
    vecs[4] = mkv(3'b010, 16'd1, 16'd0, 16'd1, 128'h77, 128'h88, 2,
                  mke(2'd2, 33'd6, 128'h77), mke(2'd2, 33'd7, 128'h88));
    vecs[5] = mkv(3'b011, 16'd1, 16'd5, 16'd6, 128'h99, 128'hAA, 1,
                  mke(2'd3, 33'd1, 128'h99), z);
    vecs[6] = mkv(3'b000, 16'd4, 16'd1, 16'd2, 128'hDE, 128'hAD, 0, z, z);
    vecs[7] = mkv(3'b101, 16'hFFFF, 16'hFFFF, 16'd0, 128'hBB, 128'h0, 1,
                  mke(2'd0, 33'h4FFFB, 128'hBB), z);
    vecs[8] = mkv(3'b010, 16'hFFFF, 16'hFFFF, 16'd0, 128'hCC, 128'hDD, 2,
                  mke(2'd2, 33'h6FFF9, 128'hCC), mke(2'd2, 33'h5FFFA, 128'hDD));

    rst = 1'b1; out_ready = 1'b0;
    set_evt(3'b000, 16'd0, 16'd0, 16'd0, '0, '0);
    cfg_input_size = 16'd4; cfg_and_count = 16'd3; cfg_cc = 16'd100;
    step(); step();
    rst = 1'b0;
    @(negedge clk);
    chk("rst_valid", 128'(out_valid), 128'd0);
    chk("rst_type", 128'(out_type), 128'd0);
    chk("rst_addr", 128'(out_addr), 128'd0);
    chk("rst_data", out_data, 128'd0);
    chk("rst_overflow", 128'(overflow), 128'd0);
    chk("rst_drop", 128'(drop_count), 128'd0);
    chk("rst_done", 128'(done), 128'd0);

    // KEY latency: captured at one edge, words on the following two cycles
    step();
    out_ready = 1'b1;
    step();
    set_evt(3'b001, 16'd0, 16'd0, 16'd0, 128'hA, 128'hB);
    exp_q.push_back(mke(2'd1, 33'd0, 128'hA));
    exp_q.push_back(mke(2'd1, 33'd1, 128'hB));
    step();
    tag_t1 = 3'b000;
    @(negedge clk);
    chk("key_w0_valid", 128'(out_valid), 128'd1);
    chk("key_w0_addr", 128'(out_addr), 128'd0);
    chk("key_w0_data", out_data, 128'hA);
    @(negedge clk);
    chk("key_w1_valid", 128'(out_valid), 128'd1);
    chk("key_w1_addr", 128'(out_addr), 128'd1);
    chk("key_w1_data", out_data, 128'hB);
    @(negedge clk);
    chk("key_empty_valid", 128'(out_valid), 128'd0);
    chk("key_empty_data", out_data, 128'd0);

    // Table-driven events through the scoreboard
    for (int i = 0; i < 9; i++) begin
      step();
      set_evt(vecs[i].tag, vecs[i].c, vecs[i].i0, vecs[i].i1, vecs[i].d0, vecs[i].d1);
      if (vecs[i].n >= 1) exp_q.push_back(vecs[i].e0);
      if (vecs[i].n >= 2) exp_q.push_back(vecs[i].e1);
      step();
      tag_t1 = 3'b000;
      repeat (3) step();
      chk($sformatf("vec%0d_drained", i), 128'(exp_q.size()), 128'd0);
    end

    // Overflow: fill with four KEY events while the consumer stalls
    step();
    out_ready = 1'b0;
    for (int k = 0; k < 4; k++) begin
      set_evt(3'b001, 16'(k), 16'd0, 16'd0, 128'(32'h100 + 2*k), 128'(32'h101 + 2*k));
      exp_q.push_back(mke(2'd1, 33'd0, 128'(32'h100 + 2*k)));
      exp_q.push_back(mke(2'd1, 33'd1, 128'(32'h101 + 2*k)));
      step();
    end
    set_evt(3'b111, 16'd2, 16'd1, 16'd3, 128'hEE, 128'hFF);
    step();
    tag_t1 = 3'b000;
    @(negedge clk);
    chk("ovf_flag", 128'(overflow), 128'd1);
    chk("ovf_drop2", 128'(drop_count), 128'd2);
    chk("ovf_head_valid", 128'(out_valid), 128'd1);
    chk("ovf_head_data", out_data, 128'h100);
    step();
    out_ready = 1'b1;
    step();
    // count is 7 here; a 2-word event must be dropped despite the same-cycle pop
    set_evt(3'b001, 16'd5, 16'd0, 16'd0, 128'hBAD0, 128'hBAD1);
    step();
    tag_t1 = 3'b000;
    repeat (10) step();
    chk("ovf_drop4", 128'(drop_count), 128'd4);
    chk("ovf_sticky", 128'(overflow), 128'd1);
    chk("ovf_drained", 128'(exp_q.size()), 128'd0);
    chk("ovf_empty", 128'(out_valid), 128'd0);

    // Completion with cfg_cc=2
    rst = 1'b1; out_ready = 1'b0; cfg_cc = 16'd2;
    step();
    rst = 1'b0;
    @(negedge clk);
    chk("rst2_overflow", 128'(overflow), 128'd0);
    chk("rst2_drop", 128'(drop_count), 128'd0);
    step();
    set_evt(3'b001, 16'd0, 16'd0, 16'd0, 128'hC0, 128'hC1);
    exp_q.push_back(mke(2'd1, 33'd0, 128'hC0));
    exp_q.push_back(mke(2'd1, 33'd1, 128'hC1));
    step();
    set_evt(3'b011, 16'd1, 16'd0, 16'd0, 128'hC2, 128'hC3);
    exp_q.push_back(mke(2'd3, 33'd1, 128'hC2));
    step();
    set_evt(3'b001, 16'd2, 16'd0, 16'd0, 128'hD0, 128'hD1);
    step();
    set_evt(3'b001, 16'd3, 16'd0, 16'd0, 128'hD2, 128'hD3);
    step();
    tag_t1 = 3'b000;
    @(negedge clk);
    chk("cmp_not_done", 128'(done), 128'd0);
    chk("cmp_valid", 128'(out_valid), 128'd1);
    step();
    out_ready = 1'b1;
    step(); step(); step();
    @(negedge clk);
    chk("cmp_empty", 128'(out_valid), 128'd0);
    chk("cmp_done_late", 128'(done), 128'd0);
    step();
    @(negedge clk);
    chk("cmp_done", 128'(done), 128'd1);
    chk("cmp_drained", 128'(exp_q.size()), 128'd0);
    chk("cmp_no_drop", 128'(drop_count), 128'd0);

    // Reset mid-drain discards buffered words and clears done
    step();
    rst = 1'b1; cfg_cc = 16'd100; out_ready = 1'b0;
    step();
    rst = 1'b0;
    @(negedge clk);
    chk("rst3_done", 128'(done), 128'd0);
    step();
    set_evt(3'b001, 16'd0, 16'd0, 16'd0, 128'hE0, 128'hE1);
    step();
    set_evt(3'b001, 16'd1, 16'd0, 16'd0, 128'hE2, 128'hE3);
    step();
    tag_t1 = 3'b000;
    @(negedge clk);
    chk("mid_valid", 128'(out_valid), 128'd1);
    chk("mid_data", out_data, 128'hE0);
    step();
    rst = 1'b1;
    step();
    rst = 1'b0; out_ready = 1'b1;
    @(negedge clk);
    chk("mid_rst_valid", 128'(out_valid), 128'd0);
    chk("mid_rst_data", out_data, 128'd0);
    chk("mid_rst_done", 128'(done), 128'd0);
    repeat (3) step();
    chk("mid_rst_stays_empty", 128'(out_valid), 128'd0);

    // cfg_cc=0 finishes on the first sampled cycle
    cfg_cc = 16'd0; rst = 1'b1;
    step();
    rst = 1'b0;
    set_evt(3'b001, 16'd0, 16'd0, 16'd0, 128'hF0, 128'hF1);
    step();
    tag_t1 = 3'b000;
    step();
    @(negedge clk);
    chk("cc0_valid", 128'(out_valid), 128'd0);
    chk("cc0_done", 128'(done), 128'd1);

    step();
    chk("final_queue", 128'(exp_q.size()), 128'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
